dot_product_engine: RTL and testbench

- Avalon-MM accelerator that consumes the weight and activation vectors placed in SDRAM by the word-copy stage.
- Computes one neuron output: the signed Q16.16 dot product of a weight vector and an input vector, plus bias, with optional ReLU.
- The CPU configures it and starts it through a slave port. It fetches operands through a read-only SDRAM master port.
- The CPU reads the result through the slave port, stalled by waitrequest until the computation completes.

---
 rtl/dot_product_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_dot_product_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_engine.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_engine
// Description : Avalon-MM neuron accelerator. Computes the signed Q16.16 dot
//               product of a weight vector and an activation vector fetched
//               from SDRAM, adds a bias and optionally applies ReLU.
// Ports       : clk, rst_n               - clock, async active-low reset
//               slave_*                  - CPU configuration/result port
//                                          (stalled by waitrequest while busy)
//               master_*                 - read-only SDRAM master port
//                                          (one outstanding read at a time)
// Register map: 0 START(w)/RESULT(r), 1 BIAS, 2 W_ADDR, 3 X_ADDR, 4 LEN,
//               5 CTRL (bit0 = ReLU enable)
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_engine #(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              slave_waitrequest,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    output logic [DATA_W-1:0] slave_readdata,
    input  logic              slave_write,
    input  logic [DATA_W-1:0] slave_writedata,
    input  logic              master_waitrequest,
    output logic [DATA_W-1:0] master_address,
    output logic              master_read,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ_W  = 3'd1;
    localparam logic [2:0] S_WAIT_W = 3'd2;
    localparam logic [2:0] S_REQ_X  = 3'd3;
    localparam logic [2:0] S_WAIT_X = 3'd4;
    localparam logic [2:0] S_MAC    = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    localparam logic [3:0] C_REG_START = 4'd0;
    localparam logic [3:0] C_REG_BIAS  = 4'd1;
    localparam logic [3:0] C_REG_WADDR = 4'd2;
    localparam logic [3:0] C_REG_XADDR = 4'd3;
    localparam logic [3:0] C_REG_LEN   = 4'd4;
    localparam logic [3:0] C_REG_CTRL  = 4'd5;

    localparam logic [DATA_W-1:0] C_WORD_BYTES = DATA_W'(4);
    localparam logic [DATA_W-1:0] C_ONE        = DATA_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;

    // Configuration registers (untouched by a run)
    logic [DATA_W-1:0] r_bias;
    logic [DATA_W-1:0] r_w_addr;
    logic [DATA_W-1:0] r_x_addr;
    logic [DATA_W-1:0] r_len;
    logic              r_relu;

    // Run-time datapath
    logic [DATA_W-1:0] r_wp;
    logic [DATA_W-1:0] r_xp;
    logic [DATA_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_w;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_result;

    logic                       w_idle;
    logic                       w_slave_wr;
    logic                       w_start;
    logic signed [2*DATA_W-1:0] w_product;
    logic [DATA_W-1:0]          w_mac_sum;
    logic [DATA_W-1:0]          w_biased;
    logic                       w_unused;

    assign w_idle     = (r_state == S_IDLE);
    // Slave accesses are only accepted in IDLE; otherwise waitrequest holds them off.
    assign w_slave_wr = slave_write && w_idle;
    assign w_start    = w_slave_wr && (slave_address == C_REG_START);

    // Full-precision signed product; the Q16.16 result is the middle word,
    // truncated toward minus infinity and wrapped to 32 bits.
    assign w_product = $signed(r_w) * $signed(r_x);
    assign w_mac_sum = r_acc + w_product[DATA_W+FRAC_BITS-1:FRAC_BITS];
    assign w_biased  = r_acc + r_bias;

    // Discarded product bits, gathered so they are visibly intentional.
    assign w_unused = ^{w_product[2*DATA_W-1:DATA_W+FRAC_BITS], w_product[FRAC_BITS-1:0]};

    // ------------------------------------------------------------------------
    // Configuration register writes
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bias   <= '0;
            r_w_addr <= '0;
            r_x_addr <= '0;
            r_len    <= '0;
            r_relu   <= 1'b0;
        end else if (w_slave_wr) begin
            case (slave_address)
                C_REG_BIAS:  r_bias   <= slave_writedata;
                C_REG_WADDR: r_w_addr <= {slave_writedata[DATA_W-1:2], 2'b00};
                C_REG_XADDR: r_x_addr <= {slave_writedata[DATA_W-1:2], 2'b00};
                C_REG_LEN:   r_len    <= slave_writedata;
                C_REG_CTRL:  r_relu   <= slave_writedata[0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: pointers, counter, operand capture, accumulator, result
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp     <= '0;
            r_xp     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_w      <= '0;
            r_x      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_wp  <= r_w_addr;
                        r_xp  <= r_x_addr;
                        r_cnt <= r_len;
                        r_acc <= '0;
                    end
                end
                S_WAIT_W: begin
                    if (master_readdatavalid) begin
                        r_w <= master_readdata;
                    end
                end
                S_WAIT_X: begin
                    if (master_readdatavalid) begin
                        r_x <= master_readdata;
                    end
                end
                S_MAC: begin
                    r_acc <= w_mac_sum;
                    r_wp  <= r_wp + C_WORD_BYTES;
                    r_xp  <= r_xp + C_WORD_BYTES;
                    r_cnt <= r_cnt - C_ONE;
                end
                S_FINISH: begin
                    r_result <= (r_relu && w_biased[DATA_W-1]) ? '0 : w_biased;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = (r_len == '0) ? S_FINISH : S_REQ_W;
                end
            end
            S_REQ_W: begin
                if (!master_waitrequest) begin
                    w_next_state = S_WAIT_W;
                end
            end
            S_WAIT_W: begin
                if (master_readdatavalid) begin
                    w_next_state = S_REQ_X;
                end
            end
            S_REQ_X: begin
                if (!master_waitrequest) begin
                    w_next_state = S_WAIT_X;
                end
            end
            S_WAIT_X: begin
                if (master_readdatavalid) begin
                    w_next_state = S_MAC;
                end
            end
            S_MAC: begin
                // r_cnt still holds the pre-decrement count here.
                w_next_state = (r_cnt == C_ONE) ? S_FINISH : S_REQ_W;
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. All decoded from the state register alone, so an
    // asynchronous reset drops master_read and waitrequest immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        slave_waitrequest = !w_idle;
        master_read       = 1'b0;
        master_address    = '0;
        case (r_state)
            S_REQ_W: begin
                master_read    = 1'b1;
                master_address = r_wp;
            end
            S_REQ_X: begin
                master_read    = 1'b1;
                master_address = r_xp;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Slave read mux (zero wait states in IDLE)
    // ------------------------------------------------------------------------
    always_comb begin
        slave_readdata = '0;
        if (slave_read && w_idle) begin
            case (slave_address)
                C_REG_START: slave_readdata = r_result;
                C_REG_BIAS:  slave_readdata = r_bias;
                C_REG_WADDR: slave_readdata = r_w_addr;
                C_REG_XADDR: slave_readdata = r_x_addr;
                C_REG_LEN:   slave_readdata = r_len;
                C_REG_CTRL:  slave_readdata = {{(DATA_W-1){1'b0}}, r_relu};
                default:     slave_readdata = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_product_engine
// Description : Scoreboard bench for dot_product_engine. CPU reads push the
//               expected value; a monitor pops and compares when the slave
//               port completes a read. A behavioural SDRAM model with
//               programmable stall and read latency serves the master port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_product_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;

    dot_product_engine #(.DATA_W(32), .FRAC_BITS(16)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] acc_log[$];
    int          stall_cycles = 0;
    int          valid_lat    = 0;
    bit          inject_valid = 1'b0;
    int          rd_hi        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (slave_read && !slave_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got 0x%08h expected no read", slave_readdata);
                end else begin
                    check(name_q.pop_front(), slave_readdata, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- SDRAM model ----------------
    initial begin
        bit          pend    = 1'b0;
        bit          offered = 1'b0;
        int          vcnt    = 0;
        int          scnt    = 0;
        logic [31:0] paddr   = '0;
        logic [31:0] oaddr   = '0;
        logic [31:0] held    = '0;
        master_waitrequest   = 1'b1;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        forever begin
            @(negedge clk);
            master_readdatavalid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0; offered = 1'b0; scnt = 0;
                master_waitrequest = 1'b1;
                continue;
            end
            if (master_read) rd_hi++;
            // A request offered with waitrequest low was accepted at the last edge.
            if (offered) begin
                offered = 1'b0; pend = 1'b1; vcnt = valid_lat; paddr = oaddr;
                acc_log.push_back(oaddr);
            end
            if (pend) begin
                if (vcnt == 0) begin
                    pend = 1'b0;
                    master_readdatavalid = 1'b1;
                    master_readdata = mem.exists(paddr) ? mem[paddr] : 32'h0;
                end else begin
                    vcnt--;
                end
            end else if (inject_valid) begin
                inject_valid = 1'b0;
                master_readdatavalid = 1'b1;
                master_readdata = 32'h1234_5678;
            end
            if (master_read) begin
                if (scnt > 0) check("stall_addr_stable", master_address, held);
                if (scnt < stall_cycles) begin
                    if (scnt == 0) held = master_address;
                    master_waitrequest = 1'b1;
                    scnt++;
                end else begin
                    master_waitrequest = 1'b0;
                    offered = 1'b1;
                    oaddr = master_address;
                    scnt = 0;
                end
            end else begin
                if (scnt > 0) check("stall_read_held", {31'b0, master_read}, 32'd1);
                scnt = 0;
                master_waitrequest = 1'b1;
            end
        end
    end

    // ---------------- CPU tasks (called at posedge+1) ----------------
    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic slave_wait(input string what);
        int   n = 0;
        logic w;
        forever begin
            @(negedge clk);
            w = slave_waitrequest;
            @(posedge clk); #1;
            if (!w) break;
            n++;
            if (n > 2000) begin
                checks++; failures++;
                $display("FAIL %s_timeout: got waitrequest stuck expected release", what);
                break;
            end
        end
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        slave_wait("write");
        slave_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        slave_address = a; slave_read = 1'b1;
        slave_wait("read");
        slave_read = 1'b0;
    endtask

    // START, then count busy cycles; latency counts the START cycle too.
    task automatic start_and_wait(output int lat);
        int hi = 0;
        cpu_write(4'd0, 32'h0);
        forever begin
            @(negedge clk);
            if (!slave_waitrequest) break;
            hi++;
            if (hi > 2000) begin
                checks++; failures++;
                $display("FAIL run_timeout: got busy %0d cycles expected idle", hi);
                break;
            end
        end
        sync();
        lat = hi + 1;
    endtask

    task automatic config_run(input logic [31:0] bias, input logic [31:0] wa,
                              input logic [31:0] xa, input logic [31:0] len, input logic [31:0] ctrl);
        cpu_write(4'd1, bias);
        cpu_write(4'd2, wa);
        cpu_write(4'd3, xa);
        cpu_write(4'd4, len);
        cpu_write(4'd5, ctrl);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int          lat;
        int          n;
        logic [31:0] exp_addr [6];

        mem[32'h1000] = 32'h0001_0000;  // 1.0
        mem[32'h1004] = 32'h0002_0000;  // 2.0
        mem[32'h1008] = 32'hFFFF_8000;  // -0.5
        mem[32'h2000] = 32'h0003_0000;  // 3.0
        mem[32'h2004] = 32'h0000_8000;  // 0.5
        mem[32'h2008] = 32'h0004_0000;  // 4.0
        mem[32'h3000] = 32'h7FFF_0000;
        exp_addr = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_waitrequest", {31'b0, slave_waitrequest}, 32'd0);
        check("reset_master_read", {31'b0, master_read}, 32'd0);
        check("reset_master_address", master_address, 32'd0);
        check("reset_readdata", slave_readdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sync();
        cpu_read(4'd0, 32'h0, "reset_result");

        // Vector 1: 3*1 + 2*0.5 + (-0.5)*4 = 2.0, +0.25 bias = 2.25
        config_run(32'h0000_4000, 32'h1000, 32'h2000, 32'd3, 32'd0);
        acc_log.delete();
        start_and_wait(lat);
        check("v1_latency", lat, 32'd17);  // 3*(2*2+1)+2 with zero-wait SDRAM
        check("v1_read_count", acc_log.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < acc_log.size()) check($sformatf("v1_read_addr%0d", i), acc_log[i], exp_addr[i]);
        end
        cpu_read(4'd0, 32'h0002_4000, "v1_result");

        // Register readback, alignment and unmapped offsets
        cpu_write(4'd2, 32'h0000_1003);
        cpu_read(4'd2, 32'h0000_1000, "waddr_aligned");
        cpu_write(4'd2, 32'h0000_1000);
        cpu_read(4'd1, 32'h0000_4000, "bias_readback");
        cpu_read(4'd4, 32'd3, "len_readback");
        cpu_read(4'd5, 32'd0, "ctrl_readback");
        cpu_write(4'd7, 32'hFFFF_FFFF);
        cpu_read(4'd7, 32'h0, "unmapped_read");

        // Bias -5.0: 2.0 - 5.0 = -3.0
        cpu_write(4'd1, 32'hFFFB_0000);
        start_and_wait(lat);
        cpu_read(4'd0, 32'hFFFD_0000, "neg_result");
        cpu_write(4'd5, 32'd1);
        cpu_read(4'd5, 32'd1, "ctrl_relu_readback");
        start_and_wait(lat);
        cpu_read(4'd0, 32'h0, "relu_result");
        cpu_write(4'd5, 32'd0);

        // LEN = 0: bias only, no SDRAM traffic
        config_run(32'h0001_8000, 32'h1000, 32'h2000, 32'd0, 32'd0);
        rd_hi = 0;
        acc_log.delete();
        start_and_wait(lat);
        check("len0_latency", lat, 32'd2);
        check("len0_master_read_cycles", rd_hi, 32'd0);
        cpu_read(4'd0, 32'h0001_8000, "len0_result");

        // Stalled SDRAM; a RESULT read right after START is held off
        config_run(32'h0000_4000, 32'h1000, 32'h2000, 32'd3, 32'd0);
        stall_cycles = 5;
        valid_lat    = 2;   // valid seen 3 cycles after accept
        cpu_write(4'd0, 32'h0);
        cpu_read(4'd0, 32'h0002_4000, "stall_result");
        stall_cycles = 0;
        valid_lat    = 0;

        // Max positive operands: 0x7FFF0000^2 -> p[47:16] = 0x00010000
        config_run(32'h0, 32'h3000, 32'h3000, 32'd1, 32'd0);
        start_and_wait(lat);
        cpu_read(4'd0, 32'h0001_0000, "wrap_result");
        inject_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("spurious_valid_idle", {31'b0, slave_waitrequest}, 32'd0);
            check("spurious_valid_no_read", {31'b0, master_read}, 32'd0);
        end
        sync();
        cpu_read(4'd0, 32'h0001_0000, "spurious_result_kept");

        // Reset mid-run, after the second MAC (third W fetch pending)
        config_run(32'h0000_4000, 32'h1000, 32'h2000, 32'd3, 32'd0);
        cpu_write(4'd0, 32'h0);
        n = 0;
        forever begin
            @(negedge clk);
            if (master_read && master_address == 32'h1008) break;
            n++;
            if (n > 500) begin
                checks++; failures++;
                $display("FAIL midrun_detect_timeout: got no W+8 request expected one");
                break;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        check("midrun_reset_master_read", {31'b0, master_read}, 32'd0);
        check("midrun_reset_waitrequest", {31'b0, slave_waitrequest}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sync();
        cpu_read(4'd0, 32'h0, "midrun_reset_result");
        config_run(32'h0000_4000, 32'h1000, 32'h2000, 32'd3, 32'd0);
        start_and_wait(lat);
        cpu_read(4'd0, 32'h0002_4000, "rerun_result");

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
